// File: rtl/m_proc12.sv
// Five-stage in-order 32-bit processor core: IF/ID/EX/MEM/WB with branches resolved in ID,
// one architectural delay slot, optional operand forwarding, and synchronous instruction/data memories.
module m_proc12 #(
  parameter int IMEM_AW  = 12,
  parameter int DMEM_AW  = 12,
  parameter int FWD_EN   = 1,
  parameter int ROUT_REG = 30
) (
  input  logic               w_clk,
  input  logic               w_rst_n,
  input  logic               w_iwe,
  input  logic [IMEM_AW-1:0] w_iaddr,
  input  logic [31:0]        w_idata,
  input  logic [4:0]         w_dbg_addr,
  output logic [31:0]        w_dbg_data,
  output logic [31:0]        r_rout,
  output logic               r_halt,
  output logic [31:0]        r_icnt
);

  localparam int         PCW      = IMEM_AW + 2;
  localparam logic [4:0] ROUT_IDX = 5'(ROUT_REG);
  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_HALT  = 6'h11;

  function automatic logic signed [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  // A producer with a real destination register that a used source of the consumer reads.
  function automatic logic hit(input logic vld, input logic [4:0] dst,
                               input logic use_src, input logic [4:0] src);
    return vld && use_src && (dst != 5'd0) && (dst == src);
  endfunction

  logic [31:0] imem [2**IMEM_AW];
  logic [31:0] dmem [2**DMEM_AW];
  logic [31:0] rf   [32];

  // control state
  logic [PCW-1:0] pc;
  logic           fetch_stop;
  logic           vld_p0, vld_p1, vld_p2, vld_p3;

  // IF/ID
  logic [31:0]    instr_p0;
  logic [PCW-1:0] pc_p0;
  // ID/EX
  logic [31:0]        a_p1, b_p1;
  logic signed [31:0] simm_p1;
  logic [4:0]         rs_p1, rt_p1, dst_p1;
  logic               add_p1, lw_p1, sw_p1, halt_p1;
  // EX/MEM
  logic [31:0] alu_p2, sd_p2;
  logic [4:0]  dst_p2;
  logic        lw_p2, sw_p2, halt_p2;
  // MEM/WB
  logic [31:0] alu_p3, ld_p3;
  logic [4:0]  dst_p3;
  logic        lw_p3, halt_p3;

  logic [5:0]         op_id;
  logic [4:0]         rs_id, rt_id, rd_id, dst_id;
  logic signed [31:0] simm_id;
  logic               is_add, is_addi, is_lw, is_sw, is_beq, is_bne, is_halt, is_br;
  logic               use_rs, use_rt, dep1, dep2, stall, id_halt, br_taken;
  logic [31:0]        rsv_id, rtv_id, cmp_a, cmp_b;
  logic [PCW-1:0]     br_target, pc_next;
  logic [31:0]        wb_val, fa, fb, alu_ex;
  logic               wb_we;
  logic [DMEM_AW-1:0] daddr;

  assign wb_val = lw_p3 ? ld_p3 : alu_p3;
  assign wb_we  = vld_p3 && (dst_p3 != 5'd0);
  assign daddr  = alu_p2[DMEM_AW+1:2];

  assign w_dbg_data = (w_dbg_addr == 5'd0) ? 32'd0 : rf[w_dbg_addr];

  always_comb begin
    op_id   = instr_p0[31:26];
    rs_id   = instr_p0[25:21];
    rt_id   = instr_p0[20:16];
    rd_id   = instr_p0[15:11];
    simm_id = sext16(instr_p0[15:0]);
    is_add  = (op_id == OP_ADD);
    is_addi = (op_id == OP_ADDI);
    is_lw   = (op_id == OP_LW);
    is_sw   = (op_id == OP_SW);
    is_beq  = (op_id == OP_BEQ);
    is_bne  = (op_id == OP_BNE);
    is_halt = (op_id == OP_HALT);
    is_br   = is_beq || is_bne;
    use_rs  = is_add || is_addi || is_lw || is_sw || is_br;
    use_rt  = is_add || is_sw || is_br;
    dst_id  = 5'd0;
    if (is_add)
      dst_id = rd_id;
    else if (is_addi || is_lw)
      dst_id = rt_id;

    // Register read with write-through from the instruction retiring this cycle.
    rsv_id = 32'd0;
    if (rs_id != 5'd0)
      rsv_id = (wb_we && dst_p3 == rs_id) ? wb_val : rf[rs_id];
    rtv_id = 32'd0;
    if (rt_id != 5'd0)
      rtv_id = (wb_we && dst_p3 == rt_id) ? wb_val : rf[rt_id];

    cmp_a = rsv_id;
    cmp_b = rtv_id;
    if (FWD_EN != 0) begin
      if (vld_p2 && !lw_p2 && dst_p2 != 5'd0 && dst_p2 == rs_id) cmp_a = alu_p2;
      if (vld_p2 && !lw_p2 && dst_p2 != 5'd0 && dst_p2 == rt_id) cmp_b = alu_p2;
    end

    dep1 = hit(vld_p1, dst_p1, use_rs, rs_id) || hit(vld_p1, dst_p1, use_rt, rt_id);
    dep2 = hit(vld_p2, dst_p2, use_rs, rs_id) || hit(vld_p2, dst_p2, use_rt, rt_id);
    if (FWD_EN != 0)
      stall = vld_p0 && (is_br ? (dep1 || (dep2 && lw_p2)) : (dep1 && lw_p1));
    else
      stall = vld_p0 && (dep1 || dep2);

    id_halt   = vld_p0 && is_halt;
    br_taken  = vld_p0 && !stall &&
                ((is_beq && cmp_a == cmp_b) || (is_bne && cmp_a != cmp_b));
    br_target = pc_p0 + PCW'(4) + {simm_id[PCW-3:0], 2'b00};
    pc_next   = br_taken ? br_target : pc + PCW'(4);
  end

  // EX operand selection: youngest producer first.
  always_comb begin
    fa = a_p1;
    fb = b_p1;
    if (FWD_EN != 0) begin
      if (vld_p2 && !lw_p2 && dst_p2 != 5'd0 && dst_p2 == rs_p1)
        fa = alu_p2;
      else if (wb_we && dst_p3 == rs_p1)
        fa = wb_val;
      if (vld_p2 && !lw_p2 && dst_p2 != 5'd0 && dst_p2 == rt_p1)
        fb = alu_p2;
      else if (wb_we && dst_p3 == rt_p1)
        fb = wb_val;
    end
    alu_ex = fa + (add_p1 ? fb : $unsigned(simm_p1));
  end

  always_ff @(posedge w_clk) begin
    if (w_iwe)
      imem[w_iaddr] <= w_idata;
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      pc         <= '0;
      fetch_stop <= 1'b0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      vld_p3     <= 1'b0;
      r_rout     <= 32'd0;
      r_halt     <= 1'b0;
      r_icnt     <= 32'd0;
      for (int i = 0; i < 32; i++)
        rf[i] <= 32'd0;
    end else begin
      // IF: HALT in ID squashes the fetch in flight and freezes the PC for good.
      if (!stall) begin
        if (id_halt) begin
          fetch_stop <= 1'b1;
          vld_p0     <= 1'b0;
        end else begin
          vld_p0 <= !fetch_stop;
          if (!fetch_stop)
            pc <= pc_next;
        end
      end
      vld_p1 <= vld_p0 && !stall;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      // WB retirement
      if (vld_p3) begin
        r_icnt <= r_icnt + 32'd1;
        if (halt_p3)
          r_halt <= 1'b1;
        if (dst_p3 != 5'd0) begin
          rf[dst_p3] <= wb_val;
          if (dst_p3 == ROUT_IDX)
            r_rout <= wb_val;
        end
      end
    end
  end

  always_ff @(posedge w_clk) begin
    // IF -> ID
    if (!stall) begin
      instr_p0 <= imem[pc[PCW-1:2]];
      pc_p0    <= pc;
    end
    // ID -> EX
    a_p1    <= rsv_id;
    b_p1    <= rtv_id;
    simm_p1 <= simm_id;
    rs_p1   <= rs_id;
    rt_p1   <= rt_id;
    dst_p1  <= dst_id;
    add_p1  <= is_add;
    lw_p1   <= is_lw;
    sw_p1   <= is_sw;
    halt_p1 <= is_halt;
    // EX -> MEM
    alu_p2  <= alu_ex;
    sd_p2   <= fb;
    dst_p2  <= dst_p1;
    lw_p2   <= lw_p1;
    sw_p2   <= sw_p1;
    halt_p2 <= halt_p1;
    // MEM -> WB
    alu_p3  <= alu_p2;
    dst_p3  <= dst_p2;
    lw_p3   <= lw_p2;
    halt_p3 <= halt_p2;
    ld_p3   <= dmem[daddr];
    if (vld_p2 && sw_p2)
      dmem[daddr] <= sd_p2;
  end

endmodule

// File: tb/tb_m_proc12.sv
// Directed bench for m_proc12: small programs run on a forwarding core and a stall-only core side by side.
module tb_m_proc12;

  logic        clk = 1'b0;
  logic        rst_n, iwe;
  logic [11:0] iaddr;
  logic [31:0] idata;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg1, rout1, icnt1, dbg0, rout0, icnt0;
  logic        halt1, halt0;

  always #5 clk = ~clk;

  m_proc12 #(.FWD_EN(1)) dut_fwd (
    .w_clk(clk), .w_rst_n(rst_n), .w_iwe(iwe), .w_iaddr(iaddr), .w_idata(idata),
    .w_dbg_addr(dbg_addr), .w_dbg_data(dbg1), .r_rout(rout1), .r_halt(halt1), .r_icnt(icnt1)
  );

  m_proc12 #(.FWD_EN(0)) dut_stall (
    .w_clk(clk), .w_rst_n(rst_n), .w_iwe(iwe), .w_iaddr(iaddr), .w_idata(idata),
    .w_dbg_addr(dbg_addr), .w_dbg_data(dbg0), .r_rout(rout0), .r_halt(halt0), .r_icnt(icnt0)
  );

  typedef struct {
    int          len;
    logic [31:0] icnt;
    logic [31:0] rout;
    int          cyc_fwd;
    int          cyc_stall;
  } prog_t;

  typedef struct {
    int          prog;
    logic [4:0]  ridx;
    logic [31:0] exp;
  } vec_t;

  prog_t       progs [9];
  logic [31:0] pm    [9][8];
  vec_t        vecs  [16];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          t_fwd, t_stall;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 11'd0};
  endfunction

  localparam logic [31:0] HALT = 32'h4400_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic load(input int p);
    rst_n = 1'b0;
    for (int i = 0; i < progs[p].len; i++) begin
      @(negedge clk);
      iwe   = 1'b1;
      iaddr = 12'(i);
      idata = pm[p][i];
    end
    @(negedge clk);
    iwe = 1'b0;
  endtask

  // Release reset and record the edge count at which each core raises r_halt.
  task automatic run();
    @(negedge clk);
    rst_n   = 1'b1;
    t_fwd   = -1;
    t_stall = -1;
    for (int c = 1; c <= 400 && (t_fwd < 0 || t_stall < 0); c++) begin
      @(posedge clk);
      #1;
      if (halt1 && t_fwd < 0)   t_fwd = c;
      if (halt0 && t_stall < 0) t_stall = c;
    end
    check("halt_fwd", {31'd0, halt1}, 32'd1);
    check("halt_stall", {31'd0, halt0}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cur;
    rst_n = 1'b1; iwe = 1'b0; iaddr = '0; idata = '0; dbg_addr = 5'd0;

    // P0: addi $1,$0,5; add $2,$1,$1; add $3,$2,$1; halt
    pm[0][0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    pm[0][1] = enc_add(5'd2, 5'd1, 5'd1);
    pm[0][2] = enc_add(5'd3, 5'd2, 5'd1);
    pm[0][3] = HALT;
    // P1: addi $1,$0,9; sw $1,8($0); lw $4,8($0); add $5,$4,$4; halt
    pm[1][0] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
    pm[1][1] = enc_i(6'h2b, 5'd0, 5'd1, 16'd8);
    pm[1][2] = enc_i(6'h23, 5'd0, 5'd4, 16'd8);
    pm[1][3] = enc_add(5'd5, 5'd4, 5'd4);
    pm[1][4] = HALT;
    // P2: addi $2,$0,3; loop: addi $2,$2,-1; bne $2,$0,loop; addi $3,$3,1; halt
    pm[2][0] = enc_i(6'h08, 5'd0, 5'd2, 16'd3);
    pm[2][1] = enc_i(6'h08, 5'd2, 5'd2, 16'hFFFF);
    pm[2][2] = enc_i(6'h05, 5'd2, 5'd0, 16'hFFFE);
    pm[2][3] = enc_i(6'h08, 5'd3, 5'd3, 16'd1);
    pm[2][4] = HALT;
    // P3: addi $0,$0,7; add $30,$0,$0; halt
    pm[3][0] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    pm[3][1] = enc_add(5'd30, 5'd0, 5'd0);
    pm[3][2] = HALT;
    // P4: addi $30,$0,0x55; halt
    pm[4][0] = enc_i(6'h08, 5'd0, 5'd30, 16'h0055);
    pm[4][1] = HALT;
    // P5: addi $7,$0,0x77; sw $7,0($0); halt
    pm[5][0] = enc_i(6'h08, 5'd0, 5'd7, 16'h0077);
    pm[5][1] = enc_i(6'h2b, 5'd0, 5'd7, 16'd0);
    pm[5][2] = HALT;
    // P6: halt; addi $6,$0,1; sw $6,0($0)
    pm[6][0] = HALT;
    pm[6][1] = enc_i(6'h08, 5'd0, 5'd6, 16'd1);
    pm[6][2] = enc_i(6'h2b, 5'd0, 5'd6, 16'd0);
    // P7: lw $8,0($0); halt
    pm[7][0] = enc_i(6'h23, 5'd0, 5'd8, 16'd0);
    pm[7][1] = HALT;
    // P8: addi $9,$0,5; sw $9,16($0); lw $10,16($0); beq $10,$9,+2; addi $11,$0,1; addi $12,$0,1; halt
    pm[8][0] = enc_i(6'h08, 5'd0, 5'd9, 16'd5);
    pm[8][1] = enc_i(6'h2b, 5'd0, 5'd9, 16'd16);
    pm[8][2] = enc_i(6'h23, 5'd0, 5'd10, 16'd16);
    pm[8][3] = enc_i(6'h04, 5'd10, 5'd9, 16'd2);
    pm[8][4] = enc_i(6'h08, 5'd0, 5'd11, 16'd1);
    pm[8][5] = enc_i(6'h08, 5'd0, 5'd12, 16'd1);
    pm[8][6] = HALT;

    progs[0] = '{4, 32'd4,  32'd0,     8, 12};
    progs[1] = '{5, 32'd5,  32'd0,    10, 13};
    progs[2] = '{5, 32'd11, 32'd0,    -1, -1};
    progs[3] = '{3, 32'd3,  32'd0,    -1, -1};
    progs[4] = '{2, 32'd2,  32'h55,   -1, -1};
    progs[5] = '{3, 32'd3,  32'd0,    -1, -1};
    progs[6] = '{3, 32'd1,  32'd0,    -1, -1};
    progs[7] = '{2, 32'd2,  32'd0,    -1, -1};
    progs[8] = '{7, 32'd6,  32'd0,    12, 14};

    vecs[0]  = '{0, 5'd1,  32'd5};
    vecs[1]  = '{0, 5'd2,  32'd10};
    vecs[2]  = '{0, 5'd3,  32'd15};
    vecs[3]  = '{1, 5'd4,  32'd9};
    vecs[4]  = '{1, 5'd5,  32'd18};
    vecs[5]  = '{2, 5'd2,  32'd0};
    vecs[6]  = '{2, 5'd3,  32'd3};
    vecs[7]  = '{3, 5'd0,  32'd0};
    vecs[8]  = '{3, 5'd30, 32'd0};
    vecs[9]  = '{4, 5'd30, 32'h55};
    vecs[10] = '{5, 5'd7,  32'h77};
    vecs[11] = '{6, 5'd6,  32'd0};
    vecs[12] = '{7, 5'd8,  32'h77};
    vecs[13] = '{8, 5'd10, 32'd5};
    vecs[14] = '{8, 5'd11, 32'd1};
    vecs[15] = '{8, 5'd12, 32'd0};

    // Reset state
    #2 rst_n = 1'b0;
    #1 dbg_addr = 5'd5;
    #1;
    check("rst_icnt_fwd", icnt1, 32'd0);
    check("rst_halt_fwd", {31'd0, halt1}, 32'd0);
    check("rst_rout_fwd", rout1, 32'd0);
    check("rst_dbg_fwd", dbg1, 32'd0);
    check("rst_icnt_stall", icnt0, 32'd0);
    check("rst_halt_stall", {31'd0, halt0}, 32'd0);
    check("rst_rout_stall", rout0, 32'd0);
    check("rst_dbg_stall", dbg0, 32'd0);

    cur = -1;
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].prog != cur) begin
        cur = vecs[i].prog;
        load(cur);
        run();
        check($sformatf("p%0d_icnt_fwd", cur), icnt1, progs[cur].icnt);
        check($sformatf("p%0d_icnt_stall", cur), icnt0, progs[cur].icnt);
        check($sformatf("p%0d_rout_fwd", cur), rout1, progs[cur].rout);
        check($sformatf("p%0d_rout_stall", cur), rout0, progs[cur].rout);
        if (progs[cur].cyc_fwd > 0) begin
          check($sformatf("p%0d_cycles_fwd", cur), t_fwd, progs[cur].cyc_fwd);
          check($sformatf("p%0d_cycles_stall", cur), t_stall, progs[cur].cyc_stall);
        end
        if (cur == 0)
          check("p0_stall_minus_fwd", t_stall - t_fwd, 32'd4);
      end
      dbg_addr = vecs[i].ridx;
      #1;
      check($sformatf("p%0d_r%0d_fwd", cur, vecs[i].ridx), dbg1, vecs[i].exp);
      check($sformatf("p%0d_r%0d_stall", cur, vecs[i].ridx), dbg0, vecs[i].exp);
    end

    // Reset asserted between edges in the middle of the loop program, then a clean rerun.
    load(2);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #3;
    dbg_addr = 5'd2;
    #1;
    check("midloop_r2_live_fwd", {31'd0, dbg1 != 32'd0}, 32'd1);
    check("midloop_icnt_live_fwd", {31'd0, icnt1 != 32'd0}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_icnt_fwd", icnt1, 32'd0);
    check("midrst_halt_fwd", {31'd0, halt1}, 32'd0);
    check("midrst_rout_fwd", rout1, 32'd0);
    check("midrst_r2_fwd", dbg1, 32'd0);
    check("midrst_icnt_stall", icnt0, 32'd0);
    check("midrst_r2_stall", dbg0, 32'd0);
    run();
    check("rerun_icnt_fwd", icnt1, 32'd11);
    check("rerun_icnt_stall", icnt0, 32'd11);
    check("rerun_r2_fwd", dbg1, 32'd0);
    dbg_addr = 5'd3;
    #1;
    check("rerun_r3_fwd", dbg1, 32'd3);
    check("rerun_r3_stall", dbg0, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/m_proc12.md
M_PROC12 -- requirements
Module: m_proc12

Interface
REQ-001 Parameter IMEM_AW, default 12, instruction memory word-address width (2^IMEM_AW words).
REQ-002 Parameter DMEM_AW, default 12, data memory word-address width (2^DMEM_AW words).
REQ-003 Parameter FWD_EN, default 1: 1 = forwarding plus minimal stalls; 0 = stall-only interlock.
REQ-004 Parameter ROUT_REG, default 30, register number mirrored on r_rout.
REQ-005 w_clk  in  1  single clock; all state changes on rising edge.
REQ-006 w_rst_n  in  1  asynchronous, active-low reset.
REQ-007 w_iwe  in  1  instruction memory write enable.
REQ-008 w_iaddr  in  IMEM_AW  instruction memory write word address.
REQ-009 w_idata  in  32  instruction memory write data.
REQ-010 w_dbg_addr  in  5  debug register-file read index.
REQ-011 w_dbg_data  out  32  combinational contents of register w_dbg_addr ($0 reads 0).
REQ-012 r_rout  out  32  last value written to register ROUT_REG.
REQ-013 r_halt  out  1  high once HALT has retired; sticky until reset.
REQ-014 r_icnt  out  32  count of retired instructions, HALT included, bubbles excluded.

Function
REQ-015 Five stages IF/ID/EX/MEM/WB; imem and dmem synchronous read, 1-cycle latency; w_iwe writes imem on any edge, independent of reset.
REQ-016 Encoding: op[31:26] rs[25:21] rt[20:16] rd[15:11] imm[15:0]; ADD=0x00 (funct ignored, writes rd), ADDI=0x08, LW=0x23, SW=0x2b, BEQ=0x04, BNE=0x05, HALT=0x11; any other op is a NOP.
REQ-017 ADDI/LW/SW use sign-extended imm; dmem word address = rs+imm bits [DMEM_AW+1:2]; all arithmetic mod 2^32.
REQ-018 BEQ/BNE resolve in ID; target = pc+4+(simm<<2); exactly one delay slot, always executed; no flush.
REQ-019 PC wraps modulo 2^(IMEM_AW+2).
REQ-020 $0 reads 0; writes to $0 discarded, never forwarded, never cause stalls.
REQ-021 Register file write-through: a WB write and a same-cycle ID read of that register return the new value.
REQ-022 FWD_EN=1: EX operands forwarded from EX/MEM ALU result (non-LW) and WB result, youngest producer first.
REQ-023 FWD_EN=1: LW in EX with dependent consumer in ID -> exactly 1 stall cycle (bubble into EX, PC and IF/ID held).
REQ-024 FWD_EN=1: branch in ID with ALU producer in EX -> 1 stall; LW producer in EX -> 2 stalls; LW in MEM -> 1 stall; EX/MEM ALU result and WB result forwarded to compare.
REQ-025 FWD_EN=0: consumer held in ID until its producer is in WB (write-through supplies the value).
REQ-026 SW data (rt) follows the same forwarding/stall rules as ALU operands.
REQ-027 HALT decoded in ID: PC frozen, instruction then in IF squashed, no further fetch; older instructions complete normally.
REQ-028 HALT in WB: r_halt set next edge; r_icnt counts it; no further architectural change until reset.
REQ-029 r_rout updates on the edge that writes ROUT_REG; unchanged otherwise.

Reset
REQ-030 w_rst_n low asynchronously clears PC, all pipeline valids (bubbles), 32 registers, r_rout, r_halt, r_icnt to 0; imem/dmem contents retained.
REQ-031 Reset asserted mid-program aborts in-flight instructions with no register or dmem write; fetch restarts at address 0 on the first edge after release.

Verification
REQ-032 addi $1,$0,5; add $2,$1,$1; add $3,$2,$1; halt -> $2=10, $3=15, r_icnt=4; FWD_EN=0 reaches r_halt exactly 4 cycles later than FWD_EN=1.
REQ-033 addi $1,$0,9; sw $1,8($0); lw $4,8($0); add $5,$4,$4; halt -> $5=18, exactly 1 stall (FWD_EN=1).
REQ-034 addi $2,$0,3; loop: addi $2,$2,-1; bne $2,$0,loop; addi $3,$3,1 (delay slot); halt -> $2=0, $3=3.
REQ-035 addi $0,$0,7; add $30,$0,$0; halt -> w_dbg_data($0)=0, r_rout=0; then addi $30,$0,0x55 -> r_rout=0x55.
REQ-036 halt; addi $6,$0,1; sw $6,0($0) -> $6=0, dmem[0] unchanged, r_icnt=1.
REQ-037 Drop w_rst_n mid-loop (REQ-034), between edges -> all outputs 0 immediately; after release program reruns to identical results.
